lsu_bus: RTL and testbench

- Load/store responder for the single-cycle core's memory control outputs: memRead, memWrite, memSignWidth (func3), ALU address and rs2 store data.
- Converts each request into a byte-lane request/acknowledge transaction on the data bus.
- Holds the core with stall until the transaction completes.
- Returns the aligned, sign- or zero-extended load result for rd writeback.
- Flags misaligned accesses, illegal widths and bus timeouts.

---
 rtl/lsu_bus.sv | 194 +++++++++++++++++++
 tb/tb_lsu_bus.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus.sv
// lsu_bus: load/store responder between the single-cycle core and a
// byte-lane request/acknowledge data bus. A legal, aligned access stalls the
// core while the bus transaction runs. Loads return an aligned,
// sign- or zero-extended word. Misaligned accesses, illegal widths and bus
// timeouts raise a one-cycle mem_err pulse.
module lsu_bus #(
    parameter int TIMEOUT = 256   // BUSY cycles to wait for bus_ack; 0 waits forever
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  memSignWidth,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter only has to reach TIMEOUT-1.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // func3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Access attributes captured at request time and used when ack returns.
    logic             ld_q;
    logic [2:0]       f3_q;
    logic [1:0]       lane_q;

    logic             req;
    logic             is_store;
    logic             legal;
    logic             aligned;
    logic             accept;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      shifted;
    logic [31:0]      ld_fmt;

    // Decode the core's request: legality, alignment and store lane placement.
    // NOTE: every signal assigned in always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        req      = memRead | memWrite;
        is_store = memWrite;          // both high counts as a store
        legal    = 1'b0;
        aligned  = 1'b1;
        st_be    = 4'b1111;
        st_wdata = wdata;

        case (memSignWidth)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~is_store;
            default:          legal = 1'b0;
        endcase

        case (memSignWidth[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        case (memSignWidth[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata;
            end
        endcase

        accept = req & legal & aligned;
    end

    // Shift the addressed byte/half down to lane 0 and extend it for writeback.
    always_comb begin
        shifted = bus_rdata >> {lane_q, 3'b000};
        ld_fmt  = shifted;
        case (f3_q)
            F3_B:    ld_fmt = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_fmt = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_fmt = {24'h0, shifted[7:0]};
            F3_HU:   ld_fmt = {16'h0, shifted[15:0]};
            default: ld_fmt = bus_rdata;
        endcase
    end

    // Hold the core from the accepting cycle through the last BUSY cycle.
    // stall stays low in DONE so the core can retire the instruction.
    always_comb begin
        stall = ((state == IDLE) & accept) | (state == BUSY);
    end

    // Transaction FSM with registered bus outputs, load result and error pulse.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_q      <= 1'b0;
            f3_q      <= 3'b000;
            lane_q    <= 2'b00;
            rdata     <= 32'h0;
            mem_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!accept) begin
                            // Rejected: flag it, touch neither the bus nor rdata.
                            mem_err <= 1'b1;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= is_store;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= is_store ? st_be : 4'b1111;
                            bus_wdata <= is_store ? st_wdata : 32'h0;
                            ld_q      <= ~is_store;
                            f3_q      <= memSignWidth;
                            lane_q    <= addr[1:0];
                            cnt       <= '0;
                            state     <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (ld_q) begin
                            rdata <= ld_fmt;
                        end
                        state <= DONE;
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        // Bus never answered: abort, keep the old rdata.
                        bus_req <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    // The request still visible this cycle is the one just
                    // retired, so it is not sampled again.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: table-driven checks of lsu_bus, followed by hand-written
// sequences for the late ack, the mid-transaction reset and recovery.
module tb_lsu_bus;

    localparam int TB_TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  memSignWidth;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int checks   = 0;
    int failures = 0;

    lsu_bus #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memSignWidth (memSignWidth),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .stall        (stall),
        .mem_err      (mem_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ACK: bus answers in BUSY cycle ack_k; TIMEOUT: never answers; REJECT: error in IDLE
    typedef enum logic [1:0] {K_ACK, K_TIMEOUT, K_REJECT} kind_e;

    typedef struct {
        kind_e       kind;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        int          ack_k;
        logic        exp_we;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic        chk_wdata;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input kind_e kind, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] brd,
                                input int ack_k, input logic we, input logic [31:0] baddr,
                                input logic [3:0] be, input logic chkw,
                                input logic [31:0] bwd, input logic [31:0] rd_exp);
        vec_t v;
        v.kind = kind;  v.rd = rd;  v.wr = wr;  v.f3 = f3;  v.addr = a;
        v.wdata = wd;   v.brdata = brd;  v.ack_k = ack_k;  v.exp_we = we;
        v.exp_baddr = baddr;  v.exp_be = be;  v.chk_wdata = chkw;
        v.exp_bwdata = bwd;   v.exp_rdata = rd_exp;
        return v;
    endfunction

    // Drive one request at a negedge and follow it to completion.
    task automatic run_row(input int idx, input vec_t v);
        int    req_cycles;
        int    stall_cycles;
        int    exp_req;
        int    n;
        bit    done;
        string tag;
        tag = $sformatf("row%0d", idx);
        @(negedge clk);
        memRead      = v.rd;
        memWrite     = v.wr;
        memSignWidth = v.f3;
        addr         = v.addr;
        wdata        = v.wdata;
        bus_rdata    = v.brdata;
        bus_ack      = 1'b0;
        #1;
        if (v.kind == K_REJECT) begin
            check($sformatf("%s idle_stall", tag), 32'(stall), 32'd0);
            @(negedge clk);
            check($sformatf("%s err_pulse", tag), 32'(mem_err), 32'd1);
            check($sformatf("%s err_no_req", tag), 32'(bus_req), 32'd0);
            check($sformatf("%s err_rdata", tag), rdata, v.exp_rdata);
            memRead  = 1'b0;
            memWrite = 1'b0;
            @(negedge clk);
            check($sformatf("%s err_one_cycle", tag), 32'(mem_err), 32'd0);
            check($sformatf("%s err_no_req2", tag), 32'(bus_req), 32'd0);
        end else begin
            stall_cycles = stall ? 1 : 0;
            req_cycles   = 0;
            n            = 0;
            done         = 1'b0;
            while (!done && n < 64) begin
                @(negedge clk);
                n++;
                bus_ack = 1'b0;
                if (bus_req) begin
                    req_cycles++;
                    check($sformatf("%s we", tag), 32'(bus_we), 32'(v.exp_we));
                    check($sformatf("%s bus_addr", tag), bus_addr, v.exp_baddr);
                    check($sformatf("%s bus_be", tag), 32'(bus_be), 32'(v.exp_be));
                    if (v.chk_wdata)
                        check($sformatf("%s bus_wdata", tag), bus_wdata, v.exp_bwdata);
                    if (v.kind == K_ACK && req_cycles == v.ack_k)
                        bus_ack = 1'b1;
                end
                #1;
                if (stall) stall_cycles++;
                else       done = 1'b1;
            end
            exp_req = (v.kind == K_ACK) ? v.ack_k : TB_TIMEOUT;
            check($sformatf("%s reached_done", tag), 32'(done), 32'd1);
            check($sformatf("%s req_cycles", tag), 32'(req_cycles), 32'(exp_req));
            check($sformatf("%s stall_cycles", tag), 32'(stall_cycles), 32'(exp_req + 1));
            check($sformatf("%s done_req_low", tag), 32'(bus_req), 32'd0);
            check($sformatf("%s done_err", tag), 32'(mem_err), 32'(v.kind == K_TIMEOUT));
            check($sformatf("%s rdata", tag), rdata, v.exp_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        memSignWidth = 3'b000;
        addr         = 32'h0;
        wdata        = 32'h0;
        bus_rdata    = 32'h0;
        bus_ack      = 1'b0;

        //          kind       rd wr f3      addr          wdata         bus_rdata     k  we baddr         be       chkw bus_wdata     rdata
        vecs.push_back(mk(K_ACK,    1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 1, 0, 32'h100, 4'b1111, 0, 32'h0,        32'hFFFFFF80)); // LB
        vecs.push_back(mk(K_ACK,    1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 1, 0, 32'h100, 4'b1111, 0, 32'h0,        32'h00000080)); // LBU
        vecs.push_back(mk(K_ACK,    0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        1, 1, 32'h100, 4'b1100, 1, 32'hABCDABCD, 32'h00000080)); // SH
        vecs.push_back(mk(K_ACK,    0, 1, 3'b000, 32'h201, 32'h0000005A, 32'h0,        2, 1, 32'h200, 4'b0010, 1, 32'h5A5A5A5A, 32'h00000080)); // SB
        vecs.push_back(mk(K_ACK,    1, 0, 3'b101, 32'h002, 32'h0,        32'hBEEF0000, 3, 0, 32'h000, 4'b1111, 0, 32'h0,        32'h0000BEEF)); // LHU
        vecs.push_back(mk(K_REJECT, 1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 0, 32'h0,        32'h0000BEEF)); // LW misaligned
        vecs.push_back(mk(K_REJECT, 1, 0, 3'b011, 32'h010, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 0, 32'h0,        32'h0000BEEF)); // func3 011
        vecs.push_back(mk(K_ACK,    1, 0, 3'b001, 32'h006, 32'h0,        32'h80010000, 1, 0, 32'h004, 4'b1111, 0, 32'h0,        32'hFFFF8001)); // LH upper half
        vecs.push_back(mk(K_ACK,    1, 1, 3'b010, 32'h020, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 1, 32'h020, 4'b1111, 1, 32'hDEADBEEF, 32'hFFFF8001)); // both high: store
        vecs.push_back(mk(K_REJECT, 1, 0, 3'b001, 32'h001, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 0, 32'h0,        32'hFFFF8001)); // LH misaligned
        vecs.push_back(mk(K_REJECT, 0, 1, 3'b100, 32'h000, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 0, 32'h0,        32'hFFFF8001)); // store width 100
        vecs.push_back(mk(K_ACK,    1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 2, 0, 32'h100, 4'b1111, 0, 32'h0,        32'h0000007F)); // LB positive
        vecs.push_back(mk(K_ACK,    0, 1, 3'b001, 32'h000, 32'h00001357, 32'h0,        1, 1, 32'h000, 4'b0011, 1, 32'h13571357, 32'h0000007F)); // SH low half
        vecs.push_back(mk(K_REJECT, 0, 1, 3'b010, 32'h102, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 0, 32'h0,        32'h0000007F)); // SW misaligned
        vecs.push_back(mk(K_ACK,    1, 0, 3'b010, 32'h010, 32'h0,        32'h12345678, 1, 0, 32'h010, 4'b1111, 0, 32'h0,        32'h12345678)); // LW
        vecs.push_back(mk(K_ACK,    1, 0, 3'b001, 32'h002, 32'h0,        32'h7FFF0000, 1, 0, 32'h000, 4'b1111, 0, 32'h0,        32'h00007FFF)); // LH positive
        vecs.push_back(mk(K_ACK,    1, 0, 3'b000, 32'h100, 32'h0,        32'h000000FE, 1, 0, 32'h100, 4'b1111, 0, 32'h0,        32'hFFFFFFFE)); // LB lane 0
        vecs.push_back(mk(K_ACK,    0, 1, 3'b010, 32'h030, 32'hA5A50F0F, 32'h0,        1, 1, 32'h030, 4'b1111, 1, 32'hA5A50F0F, 32'hFFFFFFFE)); // SW
        vecs.push_back(mk(K_TIMEOUT,1, 0, 3'b010, 32'h040, 32'h0,        32'h99999999, 0, 0, 32'h040, 4'b1111, 0, 32'h0,        32'hFFFFFFFE)); // no ack

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst rdata", rdata, 32'h0);
        check("rst mem_err", 32'(mem_err), 32'd0);
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_we", 32'(bus_we), 32'd0);
        check("rst bus_addr", bus_addr, 32'h0);
        check("rst bus_be", 32'(bus_be), 32'd0);
        check("rst bus_wdata", bus_wdata, 32'h0);
        check("rst stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // Rows run back to back: each request is driven in the cycle after DONE.
        for (int i = 0; i < vecs.size(); i++) begin
            run_row(i, vecs[i]);
        end

        // Late ack after the timeout, with the core idle, must be ignored.
        @(negedge clk);
        memRead   = 1'b0;
        memWrite  = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h11111111;
        #1;
        check("late_ack stall", 32'(stall), 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        check("late_ack bus_req", 32'(bus_req), 32'd0);
        check("late_ack mem_err", 32'(mem_err), 32'd0);
        check("late_ack rdata", rdata, 32'hFFFFFFFE);
        @(negedge clk);
        check("late_ack still_idle", 32'(bus_req), 32'd0);

        // Reset in the second BUSY cycle aborts the transaction.
        memRead      = 1'b1;
        memSignWidth = 3'b010;
        addr         = 32'h50;
        bus_rdata    = 32'h0;
        @(negedge clk);
        check("rst_busy first_busy_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        check("rst_busy second_busy_stall", 32'(stall), 32'd1);
        rst     = 1'b1;
        memRead = 1'b0;
        @(negedge clk);
        check("rst_busy bus_req", 32'(bus_req), 32'd0);
        check("rst_busy stall", 32'(stall), 32'd0);
        check("rst_busy rdata", rdata, 32'h0);
        check("rst_busy mem_err", 32'(mem_err), 32'd0);
        rst = 1'b0;

        // Normal load after the abort.
        run_row(100, mk(K_ACK, 1, 0, 3'b010, 32'h010, 32'h0, 32'hCAFEF00D, 1, 0, 32'h010,
                        4'b1111, 0, 32'h0, 32'hCAFEF00D));
        @(negedge clk);
        memRead  = 1'b0;
        memWrite = 1'b0;
        @(negedge clk);
        check("final idle bus_req", 32'(bus_req), 32'd0);
        check("final rdata hold", rdata, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
